// File: rtl/empacota_instrucao.sv
// -----------------------------------------------------------------------------
// empacota_instrucao
//
// Instruction encoder and program loader. Accepts R/I/J instruction fields over
// a valid/ready handshake, packs them into a 32-bit MIPS word, and writes each
// word to consecutive instruction-memory addresses using a write/ack handshake.
// It fills instruction memory before the core is released.
//
// Parameters
//   ADDR_W     instruction-memory word-address width
//   BASE_ADDR  first address written after reset or clear
//
// Optional feature
//   ENCODER_CHECK_EN  when defined, field sets whose opcode is inconsistent
//                     with their format are discarded (erro pulse, no write).
//                     When undefined, only formato=11 is rejected and the
//                     fields are packed verbatim.
//
// Ports
//   clock        single clock, rising edge
//   reset        asynchronous, active-high
//   in_valid     field set present
//   in_ready     block can accept a field set (IDLE only)
//   formato      00 R, 01 I, 10 J, 11 invalid
//   Op_code, Register_rs, Register_rt, Register_rd, Shamt, Funct,
//   Endereco, Alvo   instruction fields
//   clear        synchronous restart to BASE_ADDR (honoured in IDLE and FULL)
//   mem_we       write request, held until mem_ack
//   mem_addr     write word address
//   mem_data     packed instruction
//   mem_ack      memory accepted the write this cycle
//   count        words written since reset or clear
//   full         last address written; further input is ignored
//   erro         one-cycle pulse when a field set is discarded
// -----------------------------------------------------------------------------
module empacota_instrucao #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        formato,
  input  logic [5:0]        Op_code,
  input  logic [4:0]        Register_rs,
  input  logic [4:0]        Register_rt,
  input  logic [4:0]        Register_rd,
  input  logic [4:0]        Shamt,
  input  logic [5:0]        Funct,
  input  logic [15:0]       Endereco,
  input  logic [25:0]       Alvo,
  input  logic              clear,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  input  logic              mem_ack,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              erro
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [1:0] FMT_R = 2'b00;
  localparam logic [1:0] FMT_I = 2'b01;
  localparam logic [1:0] FMT_J = 2'b10;

  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  state_t      state;
  logic [31:0] packed_word;
  logic        fields_ok;

  // Pack the incoming field set and decide whether it may be written.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch is never inferred.
    packed_word = 32'h0;
    fields_ok   = 1'b1;
    unique case (formato)
      FMT_R:   packed_word = {Op_code, Register_rs, Register_rt, Register_rd, Shamt, Funct};
      FMT_I:   packed_word = {Op_code, Register_rs, Register_rt, Endereco};
      FMT_J:   packed_word = {Op_code, Alvo};
      default: fields_ok   = 1'b0;
    endcase
`ifdef ENCODER_CHECK_EN
    // Opcode/format consistency: R uses the SPECIAL opcode, J uses j/jal,
    // and I may use anything else.
    unique case (formato)
      FMT_R:   if (Op_code != 6'b000000) fields_ok = 1'b0;
      FMT_I:   if (Op_code == 6'b000000 || Op_code == 6'b000010 ||
                   Op_code == 6'b000011) fields_ok = 1'b0;
      FMT_J:   if (Op_code != 6'b000010 && Op_code != 6'b000011) fields_ok = 1'b0;
      default: fields_ok = 1'b0;
    endcase
`endif
  end

  // Control FSM with all outputs registered. Async reset drops mem_we at once,
  // so a write interrupted by reset is never acknowledged as complete.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      in_ready <= 1'b1;
      mem_we   <= 1'b0;
      mem_addr <= ADDR_BASE;
      mem_data <= 32'h0;
      count    <= '0;
      full     <= 1'b0;
      erro     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      erro <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (clear) begin
            // clear has priority over a simultaneous field set
            mem_addr <= ADDR_BASE;
            count    <= '0;
          end else if (in_valid) begin
            if (fields_ok) begin
              mem_data <= packed_word;
              mem_we   <= 1'b1;
              in_ready <= 1'b0;
              state    <= S_WRITE;
            end else begin
              erro <= 1'b1;
            end
          end
        end

        S_WRITE: begin
          // clear is deliberately ignored here; the write runs to completion
          if (mem_ack) begin
            mem_we <= 1'b0;
            count  <= count + (ADDR_W+1)'(1);
            if (mem_addr == ADDR_LAST) begin
              full  <= 1'b1;
              state <= S_FULL;
            end else begin
              mem_addr <= mem_addr + ADDR_W'(1);
              in_ready <= 1'b1;
              state    <= S_IDLE;
            end
          end
        end

        S_FULL: begin
          if (clear) begin
            mem_addr <= ADDR_BASE;
            count    <= '0;
            full     <= 1'b0;
            in_ready <= 1'b1;
            state    <= S_IDLE;
          end
        end

        default: begin
          mem_we   <= 1'b0;
          full     <= 1'b0;
          in_ready <= 1'b1;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_empacota_instrucao.sv
// -----------------------------------------------------------------------------
// tb_empacota_instrucao
//
// Self-checking bench for empacota_instrucao with ADDR_W=2 so the FULL
// boundary is reached often. A reference model tracks the expected address,
// count and full flag and computes packed words arithmetically from the
// field definitions. Directed cases come first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_empacota_instrucao;

  localparam int ADDR_W = 2;
  localparam int NWORDS = 1 << ADDR_W;

  logic              clock;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        formato;
  logic [5:0]        Op_code;
  logic [4:0]        Register_rs;
  logic [4:0]        Register_rt;
  logic [4:0]        Register_rd;
  logic [4:0]        Shamt;
  logic [5:0]        Funct;
  logic [15:0]       Endereco;
  logic [25:0]       Alvo;
  logic              clear;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic              mem_ack;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              erro;

  empacota_instrucao #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .formato     (formato),
    .Op_code     (Op_code),
    .Register_rs (Register_rs),
    .Register_rt (Register_rt),
    .Register_rd (Register_rd),
    .Shamt       (Shamt),
    .Funct       (Funct),
    .Endereco    (Endereco),
    .Alvo        (Alvo),
    .clear       (clear),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_ack     (mem_ack),
    .count       (count),
    .full        (full),
    .erro        (erro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_addr  = 0;
  int m_count = 0;
  bit m_full  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [1:0] fmt, input logic [5:0] op,
      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
      input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] tgt);
    logic [31:0] w;
    w = 32'(op) << 26;
    case (fmt)
      2'd0: w = w | (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
      2'd1: w = w | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
      2'd2: w = w | 32'(tgt);
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  function automatic bit model_accepts(input logic [1:0] fmt, input logic [5:0] op);
    if (fmt == 2'd3) return 1'b0;
`ifdef ENCODER_CHECK_EN
    if (fmt == 2'd0 && op != 6'd0) return 1'b0;
    if (fmt == 2'd2 && !(op == 6'd2 || op == 6'd3)) return 1'b0;
    if (fmt == 2'd1 && (op == 6'd0 || op == 6'd2 || op == 6'd3)) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_addr  = 0;
    m_count = 0;
    m_full  = 0;
  endtask

  // Offer one field set. When the model is FULL the set must be ignored.
  // ack_delay cycles of mem_we pass before mem_ack; with hold_clear the clear
  // input is held high across those cycles and must have no effect.
  task automatic send(input logic [1:0] fmt, input logic [5:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
      input logic [15:0] imm, input logic [25:0] tgt, input int ack_delay, input bit hold_clear);
    logic [31:0] w;
    int waited;
    if (!m_full) begin
      waited = 0;
      while (!in_ready && waited < 20) begin
        @(posedge clock); #1;
        waited++;
      end
      if (!in_ready) begin
        check("ready_timeout", 32'(in_ready), 32'd1);
        return;
      end
    end
    formato = fmt; Op_code = op; Register_rs = rs; Register_rt = rt; Register_rd = rd;
    Shamt = sh; Funct = fn; Endereco = imm; Alvo = tgt;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;

    if (m_full) begin
      check("full_ignore_we",    32'(mem_we),   32'd0);
      check("full_ignore_erro",  32'(erro),     32'd0);
      check("full_ignore_ready", 32'(in_ready), 32'd0);
      check("full_ignore_full",  32'(full),     32'd1);
      check("full_ignore_count", 32'(count),    32'(m_count));
      return;
    end

    if (!model_accepts(fmt, op)) begin
      check("reject_erro", 32'(erro),     32'd1);
      check("reject_we",   32'(mem_we),   32'd0);
      check("reject_addr", 32'(mem_addr), 32'(m_addr));
      @(posedge clock); #1;
      check("reject_erro_end", 32'(erro),     32'd0);
      check("reject_ready",    32'(in_ready), 32'd1);
      check("reject_count",    32'(count),    32'(m_count));
      return;
    end

    w = model_word(fmt, op, rs, rt, rd, sh, fn, imm, tgt);
    check("write_we",    32'(mem_we),   32'd1);
    check("write_addr",  32'(mem_addr), 32'(m_addr));
    check("write_data",  mem_data,      w);
    check("write_ready", 32'(in_ready), 32'd0);
    check("write_erro",  32'(erro),     32'd0);
    if (hold_clear) clear = 1'b1;
    for (int k = 0; k < ack_delay; k++) begin
      @(posedge clock); #1;
      check("hold_we",    32'(mem_we),   32'd1);
      check("hold_addr",  32'(mem_addr), 32'(m_addr));
      check("hold_data",  mem_data,      w);
      check("hold_count", 32'(count),    32'(m_count));
    end
    clear   = 1'b0;
    mem_ack = 1'b1;
    @(posedge clock); #1;
    mem_ack = 1'b0;
    m_count++;
    if (m_addr == NWORDS - 1) m_full = 1'b1;
    else m_addr++;
    check("ack_we",    32'(mem_we),   32'd0);
    check("ack_count", 32'(count),    32'(m_count));
    check("ack_addr",  32'(mem_addr), 32'(m_addr));
    check("ack_full",  32'(full),     32'(m_full));
    check("ack_ready", 32'(in_ready), 32'(!m_full));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    model_reset();
    check("clear_ready", 32'(in_ready), 32'd1);
    check("clear_addr",  32'(mem_addr), 32'd0);
    check("clear_count", 32'(count),    32'd0);
    check("clear_full",  32'(full),     32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_we"},    32'(mem_we),   32'd0);
    check({tag, "_addr"},  32'(mem_addr), 32'd0);
    check({tag, "_data"},  mem_data,      32'd0);
    check({tag, "_count"}, 32'(count),    32'd0);
    check({tag, "_full"},  32'(full),     32'd0);
    check({tag, "_erro"},  32'(erro),     32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  fmt;
    logic [5:0]  op;
    int          sel;

    reset = 1'b1; in_valid = 1'b0; clear = 1'b0; mem_ack = 1'b0;
    formato = 2'd0; Op_code = '0; Register_rs = '0; Register_rt = '0; Register_rd = '0;
    Shamt = '0; Funct = '0; Endereco = '0; Alvo = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
    check_reset_values("rst");

    // Directed: R, then I and J with three wait cycles, then an invalid format
    send(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 0, 0);
    do_clear();
    send(2'd1, 6'h23, 5'd9, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0004, 26'h0, 3, 0);
    send(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h10, 3, 0);
    send(2'd3, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 0, 0);
    // R with a non-zero opcode: written verbatim unless consistency checking is on
    send(2'd0, 6'h23, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1, 0);
    // Fill to the last address, then confirm FULL ignores input
    while (!m_full) send(2'd0, 6'h00, 5'd4, 5'd5, 5'd6, 5'd1, 6'h22, 16'h0, 26'h0, 0, 0);
    check("full_addr", 32'(mem_addr), 32'(NWORDS - 1));
    check("full_count", 32'(count), 32'(NWORDS));
    send(2'd1, 6'h08, 5'd1, 5'd1, 5'd0, 5'd0, 6'h00, 16'h1234, 26'h0, 0, 0);
    do_clear();

    // clear held through a write is ignored until the ack
    send(2'd1, 6'h0d, 5'd2, 5'd3, 5'd0, 5'd0, 6'h00, 16'hbeef, 26'h0, 2, 1);

    // clear and in_valid together in IDLE: clear wins
    formato = 2'd0; Op_code = 6'h00; Funct = 6'h21; in_valid = 1'b1; clear = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; clear = 1'b0;
    model_reset();
    check("clr_valid_we",    32'(mem_we),   32'd0);
    check("clr_valid_erro",  32'(erro),     32'd0);
    check("clr_valid_addr",  32'(mem_addr), 32'd0);
    check("clr_valid_count", 32'(count),    32'd0);
    check("clr_valid_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of a write drops mem_we without a clock edge
    send(2'd0, 6'h00, 5'd7, 5'd7, 5'd7, 5'd0, 6'h25, 16'h0, 26'h0, 0, 0);
    formato = 2'd2; Op_code = 6'h03; Alvo = 26'h3ff_ffff; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("pre_reset_we", 32'(mem_we), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_reset_values("midwrite_rst");
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    check("post_reset_we", 32'(mem_we), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 120; i++) begin
      sel = $urandom_range(0, 19);
      if (sel == 0 || (m_full && sel < 8)) begin
        do_clear();
      end else begin
        sel = $urandom_range(0, 9);
        fmt = (sel == 9) ? 2'd3 : 2'(sel % 3);
        op  = 6'($urandom);
        if (fmt == 2'd0 && $urandom_range(0, 3) != 0) op = 6'd0;
        if (fmt == 2'd2 && $urandom_range(0, 3) != 0) op = 6'($urandom_range(2, 3));
        send(fmt, op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
             16'($urandom), 26'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 4) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/empacota_instrucao.md
# empacota_instrucao

Instruction encoder and program loader for the MIPS datapath, the write-side counterpart of the field decoder. It accepts R/I/J instruction fields over a valid/ready handshake and packs them into a 32-bit word. It then writes each word into consecutive instruction-memory addresses using a write/ack handshake. It sits between the testbench or boot source and instruction memory, and fills memory before the core runs.

## Interface
- ADDR_W, 8: instruction-memory word-address width.
- BASE_ADDR, 0: first address written after reset or clear.

- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  field set present.
- in_ready  out  1  block can accept a field set.
- formato  in  2  instruction format: 00 R, 01 I, 10 J, 11 invalid.
- Op_code  in  6  opcode.
- Register_rs / Register_rt / Register_rd  in  5 each  register fields.
- Shamt  in  5  shift amount.
- Funct  in  6  function code.
- Endereco  in  16  I-format immediate.
- Alvo  in  26  J-format target.
- clear  in  1  synchronous restart to BASE_ADDR; honoured in IDLE and FULL only.
- mem_we  out  1  write request.
- mem_addr  out  ADDR_W  write word address.
- mem_data  out  32  packed instruction.
- mem_ack  in  1  memory accepted the write this cycle.
- count  out  ADDR_W+1  words written since reset or clear.
- full  out  1  last address written; no further input is accepted.
- erro  out  1  one-cycle pulse when a field set is discarded.

## Operation
- States:
  - IDLE: in_ready=1.
  - WRITE: mem_we=1, in_ready=0.
  - FULL: in_ready=0, full=1.
- Packing:
  - R format: Op_code, rs, rt, rd, Shamt, Funct in bits 31:26, 25:21, 20:16, 15:11, 10:6, 5:0.
  - I format: Op_code, rs, rt, Endereco in bits 31:26, 25:21, 20:16, 15:0.
  - J format: Op_code, Alvo in bits 31:26, 25:0.
- IDLE behaviour, on in_valid & in_ready:
  - If formato=11: the set is discarded, erro pulses the next cycle, and the block stays in IDLE.
  - Otherwise: the packed word is registered into mem_data and the block goes to WRITE.
- WRITE behaviour:
  - mem_we, mem_addr and mem_data are held stable until mem_ack.
  - On mem_ack, count increments.
  - If mem_addr = 2^ADDR_W−1, go to FULL with mem_addr unchanged.
  - Otherwise, mem_addr increments and the block returns to IDLE.
- clear:
  - In IDLE or FULL: mem_addr←BASE_ADDR, count←0, go to IDLE.
  - In WRITE: ignored; the write completes normally.
  - clear and in_valid in the same IDLE cycle: clear wins and the input is not accepted.
- FULL: in_valid is ignored and erro is not asserted.
- Reset mid-write: mem_we drops immediately. The pending word is lost and memory must not treat it as written.

## Timing
- Reset values:
  - State IDLE: in_ready=1.
  - mem_we=0, mem_addr=BASE_ADDR, mem_data=0, count=0, full=0, erro=0.
- Acceptance edge T → mem_we=1 in cycle T+1 with valid mem_data.
- A zero-wait mem_ack (high in T+1) gives in_ready=1 again in T+2. Peak throughput is 1 word per 2 cycles.
- mem_ack outside WRITE is ignored.
- erro is high for exactly one cycle, following the acceptance edge of a discarded set.
- count and mem_addr update on the same edge as the accepted mem_ack.

## Configuration
- ENCODER_CHECK_EN defined: opcode/format consistency is enforced.
  - R format requires Op_code=000000.
  - J format requires Op_code ∈ {000010, 000011}.
  - I format requires Op_code ∉ {000000, 000010, 000011}.
  - Violations are discarded exactly like formato=11: erro pulse, no write.
- Undefined: only formato=11 is rejected, and fields are packed verbatim.

## Test plan
- R format (rs=1, rt=2, rd=3, Shamt=0, Funct=0x20) -> write at addr 0 with mem_data=0x00221820, count=1.
- I format (Op_code=0x23, rs=9, rt=8, Endereco=4), then J format (Op_code=2, Alvo=0x10), ack delayed 3 cycles -> mem_we held 4 cycles, words 0x8D280004 at addr 0 and 0x08000010 at addr 1.
- formato=11 -> no mem_we, erro high 1 cycle, mem_addr unchanged.
- ADDR_W=2: write 4 words -> full=1, in_ready=0, count=4, mem_addr=3. A 5th in_valid is ignored. clear -> IDLE with mem_addr=0, count=0.
- reset asserted while in WRITE -> mem_we=0 immediately and all outputs at reset values. clear asserted in WRITE -> ignored until ack.
- ENCODER_CHECK_EN: R format with Op_code=0x23 -> erro pulse, no write. Without the macro -> written as 0x8C221820.
